// File: rtl/decode_queue.sv
// RV32I ALU/shift decode stage feeding a DEPTH-entry micro-op FIFO.
// Decode is combinational on the incoming word; the queue registers the decoded entry.
package data_types;
  typedef enum logic {ALU = 1'b0, SHIFT = 1'b1} functional_group_t;
  typedef enum logic [3:0] {
    ADDI, SLTI, SLTUI, XORI, ORI, ANDI,
    ADDR, SLTR, SLTUR, XORR, ORR, ANDR, SUBR
  } alu_op_t;
  typedef enum logic [2:0] {SLLI, SRLI, SRAI, SLLR, SRLR, SRAR} shift_op_t;
endpackage

module decode_queue
  import data_types::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       instruc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output functional_group_t func_group_o,
  output alu_op_t           alu_op_type_o,
  output shift_op_t         shift_op_type_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [31:0]       imm_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    functional_group_t grp;
    alu_op_t           alu;
    shift_op_t         sh;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              illegal;
  } entry_t;

  localparam entry_t ENTRY_RST = '{grp: ALU, alu: ADDI, sh: SLLI, rd: 5'd0, rs1: 5'd0,
                                   rs2: 5'd0, imm: 32'd0, illegal: 1'b0};

  entry_t             dec;
  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  assign opcode = instruc_i[6:0];
  assign funct3 = instruc_i[14:12];
  assign funct7 = instruc_i[31:25];

  always_comb begin
    dec         = ENTRY_RST;
    dec.rd      = instruc_i[11:7];
    dec.rs1     = instruc_i[19:15];
    dec.rs2     = instruc_i[24:20];
    dec.illegal = 1'b1;
    case (opcode)
      7'b0010011: begin
        case (funct3)
          3'b000: begin dec.illegal = 1'b0; dec.alu = ADDI;  end
          3'b010: begin dec.illegal = 1'b0; dec.alu = SLTI;  end
          3'b011: begin dec.illegal = 1'b0; dec.alu = SLTUI; end
          3'b100: begin dec.illegal = 1'b0; dec.alu = XORI;  end
          3'b110: begin dec.illegal = 1'b0; dec.alu = ORI;   end
          3'b111: begin dec.illegal = 1'b0; dec.alu = ANDI;  end
          3'b001: begin
            if (funct7 == 7'b0000000) begin
              dec.illegal = 1'b0; dec.grp = SHIFT; dec.sh = SLLI;
            end
          end
          3'b101: begin
            if (funct7 == 7'b0000000) begin
              dec.illegal = 1'b0; dec.grp = SHIFT; dec.sh = SRLI;
            end else if (funct7 == 7'b0100000) begin
              dec.illegal = 1'b0; dec.grp = SHIFT; dec.sh = SRAI;
            end
          end
          default: ;
        endcase
        // shifts carry the zero-extended shamt, the rest a sign-extended I-immediate
        if (!dec.illegal) begin
          if (dec.grp == SHIFT) dec.imm = {27'd0, instruc_i[24:20]};
          else                  dec.imm = {{20{instruc_i[31]}}, instruc_i[31:20]};
        end
      end
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          dec.illegal = 1'b0;
          case (funct3)
            3'b000:  dec.alu = ADDR;
            3'b010:  dec.alu = SLTR;
            3'b011:  dec.alu = SLTUR;
            3'b100:  dec.alu = XORR;
            3'b110:  dec.alu = ORR;
            3'b111:  dec.alu = ANDR;
            3'b001:  begin dec.grp = SHIFT; dec.sh = SLLR; end
            default: begin dec.grp = SHIFT; dec.sh = SRLR; end
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) begin
            dec.illegal = 1'b0; dec.alu = SUBR;
          end else if (funct3 == 3'b101) begin
            dec.illegal = 1'b0; dec.grp = SHIFT; dec.sh = SRAR;
          end
        end
      end
      default: ;
    endcase
  end

  assign in_ready_o  = (count_q != CNT_W'(DEPTH)) && !rst_i;
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= ENTRY_RST;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  entry_t head;
  assign head            = mem_q[rd_ptr_q];
  assign func_group_o    = head.grp;
  assign alu_op_type_o   = head.alu;
  assign shift_op_type_o = head.sh;
  assign rd_o            = head.rd;
  assign rs1_o           = head.rs1;
  assign rs2_o           = head.rs2;
  assign imm_o           = head.imm;
  assign illegal_o       = head.illegal;
  assign count_o         = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode vectors, full/backpressure, flush and async reset.
module tb_decode_queue;
  import data_types::*;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              flush_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [31:0]       instruc_i = 32'd0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  functional_group_t func_group_o;
  alu_op_t           alu_op_type_o;
  shift_op_t         shift_op_type_o;
  logic [4:0]        rd_o, rs1_o, rs2_o;
  logic [31:0]       imm_o;
  logic              illegal_o;
  logic [2:0]        count_o;

  int passed = 0;
  int total  = 0;

  decode_queue #(.DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .instruc_i(instruc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .func_group_o(func_group_o), .alu_op_type_o(alu_op_type_o),
    .shift_op_type_o(shift_op_type_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .imm_o(imm_o), .illegal_o(illegal_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (count_o !== 3'd0) $display("FAIL rst_count got %0d want 0", count_o); else passed++;
    total++; if (out_valid_o !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid_o); else passed++;
    total++; if (in_ready_o !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready_o); else passed++;
    total++; if (func_group_o !== ALU || alu_op_type_o !== ADDI || shift_op_type_o !== SLLI)
      $display("FAIL rst_ops got %0d/%0d/%0d want 0/0/0", func_group_o, alu_op_type_o, shift_op_type_o); else passed++;
    total++; if (imm_o !== 32'd0 || illegal_o !== 1'b0 || rd_o !== 5'd0)
      $display("FAIL rst_payload got imm %h ill %b rd %0d want 0", imm_o, illegal_o, rd_o); else passed++;
    step();
    rst_i = 1'b0;
    #1;
    total++; if (in_ready_o !== 1'b1) $display("FAIL rel_in_ready got %b want 1", in_ready_o); else passed++;
  endtask

  task automatic test_single();
    out_ready_i = 1'b1; in_valid_i = 1'b1; instruc_i = 32'h00510093;
    step();
    in_valid_i = 1'b0;
    total++; if (out_valid_o !== 1'b1 || count_o !== 3'd1)
      $display("FAIL single_valid got v %b cnt %0d want 1/1", out_valid_o, count_o); else passed++;
    total++; if (func_group_o !== ALU || alu_op_type_o !== ADDI || illegal_o !== 1'b0)
      $display("FAIL single_op got %0d/%0d ill %b want ALU/ADDI/0", func_group_o, alu_op_type_o, illegal_o); else passed++;
    total++; if (rd_o !== 5'd1 || rs1_o !== 5'd2 || imm_o !== 32'h5)
      $display("FAIL single_fields got rd %0d rs1 %0d imm %h want 1/2/5", rd_o, rs1_o, imm_o); else passed++;
    step();
    total++; if (count_o !== 3'd0 || out_valid_o !== 1'b0)
      $display("FAIL single_pop got cnt %0d v %b want 0/0", count_o, out_valid_o); else passed++;
  endtask

  task automatic test_back_to_back();
    out_ready_i = 1'b1; in_valid_i = 1'b1; instruc_i = 32'h40725193;
    step();
    instruc_i = 32'h007342B3;
    total++; if (func_group_o !== SHIFT || shift_op_type_o !== SRAI || alu_op_type_o !== ADDI)
      $display("FAIL b2b_srai_op got %0d/%0d/%0d want SHIFT/SRAI/ADDI", func_group_o, shift_op_type_o, alu_op_type_o); else passed++;
    total++; if (rd_o !== 5'd3 || rs1_o !== 5'd4 || imm_o !== 32'd7 || illegal_o !== 1'b0)
      $display("FAIL b2b_srai_fields got rd %0d rs1 %0d imm %h ill %b want 3/4/7/0", rd_o, rs1_o, imm_o, illegal_o); else passed++;
    step();
    instruc_i = 32'hFFFFFFFF;
    total++; if (func_group_o !== ALU || alu_op_type_o !== XORR || shift_op_type_o !== SLLI || count_o !== 3'd1)
      $display("FAIL b2b_xorr_op got %0d/%0d/%0d cnt %0d want ALU/XORR/SLLI/1", func_group_o, alu_op_type_o, shift_op_type_o, count_o); else passed++;
    total++; if (rd_o !== 5'd5 || rs1_o !== 5'd6 || rs2_o !== 5'd7 || imm_o !== 32'd0)
      $display("FAIL b2b_xorr_fields got %0d/%0d/%0d imm %h want 5/6/7/0", rd_o, rs1_o, rs2_o, imm_o); else passed++;
    step();
    in_valid_i = 1'b0;
    total++; if (illegal_o !== 1'b1 || func_group_o !== ALU || alu_op_type_o !== ADDI || imm_o !== 32'd0 || rd_o !== 5'd31)
      $display("FAIL b2b_illegal got ill %b %0d/%0d imm %h rd %0d want 1 ALU/ADDI 0 31", illegal_o, func_group_o, alu_op_type_o, imm_o, rd_o); else passed++;
    step();
    total++; if (count_o !== 3'd0) $display("FAIL b2b_drain got %0d want 0", count_o); else passed++;
  endtask

  task automatic test_full_wrap();
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      instruc_i = 32'h00000093 | (32'(k) << 20);
      total++; if (in_ready_o !== 1'b1) $display("FAIL full_ready_%0d got %b want 1", k, in_ready_o); else passed++;
      step();
    end
    instruc_i = 32'h00500093;
    total++; if (count_o !== 3'd4 || in_ready_o !== 1'b0)
      $display("FAIL full_state got cnt %0d rdy %b want 4/0", count_o, in_ready_o); else passed++;
    step();
    total++; if (imm_o !== 32'd1 || out_valid_o !== 1'b1 || count_o !== 3'd4)
      $display("FAIL full_stable got imm %h v %b cnt %0d want 1/1/4", imm_o, out_valid_o, count_o); else passed++;
    out_ready_i = 1'b1;
    #1;
    total++; if (in_ready_o !== 1'b0) $display("FAIL full_no_bypass got %b want 0", in_ready_o); else passed++;
    step();
    out_ready_i = 1'b0;
    total++; if (count_o !== 3'd3 || imm_o !== 32'd2 || in_ready_o !== 1'b1)
      $display("FAIL full_pop_only got cnt %0d imm %h rdy %b want 3/2/1", count_o, imm_o, in_ready_o); else passed++;
    step();
    total++; if (count_o !== 3'd4 || in_ready_o !== 1'b0)
      $display("FAIL full_fifth got cnt %0d rdy %b want 4/0", count_o, in_ready_o); else passed++;
    out_ready_i = 1'b1; instruc_i = 32'h00600093;
    step();
    total++; if (count_o !== 3'd3 || imm_o !== 32'd3)
      $display("FAIL full_pop2 got cnt %0d imm %h want 3/3", count_o, imm_o); else passed++;
    step();
    in_valid_i = 1'b0;
    total++; if (count_o !== 3'd3 || imm_o !== 32'd4)
      $display("FAIL full_pushpop got cnt %0d imm %h want 3/4", count_o, imm_o); else passed++;
    step();
    total++; if (imm_o !== 32'd5) $display("FAIL wrap_order5 got %h want 5", imm_o); else passed++;
    step();
    total++; if (imm_o !== 32'd6 || count_o !== 3'd1) $display("FAIL wrap_order6 got %h cnt %0d want 6/1", imm_o, count_o); else passed++;
    step();
    out_ready_i = 1'b0;
    total++; if (count_o !== 3'd0) $display("FAIL wrap_drain got %0d want 0", count_o); else passed++;
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      instruc_i = 32'h00000093 | (32'(k) << 20);
      step();
    end
    total++; if (count_o !== 3'd3) $display("FAIL flush_pre got %0d want 3", count_o); else passed++;
    flush_i = 1'b1; out_ready_i = 1'b1; instruc_i = 32'h00700093;
    step();
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    total++; if (count_o !== 3'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1)
      $display("FAIL flush_state got cnt %0d v %b rdy %b want 0/0/1", count_o, out_valid_o, in_ready_o); else passed++;
    in_valid_i = 1'b1; instruc_i = 32'h00800093;
    step();
    in_valid_i = 1'b0;
    total++; if (imm_o !== 32'd8 || count_o !== 3'd1)
      $display("FAIL flush_repush got imm %h cnt %0d want 8/1", imm_o, count_o); else passed++;
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
  endtask

  task automatic test_async_reset();
    in_valid_i = 1'b1;
    instruc_i = 32'h00900093; step();
    instruc_i = 32'h00A00093; step();
    in_valid_i = 1'b0;
    total++; if (count_o !== 3'd2) $display("FAIL arst_pre got %0d want 2", count_o); else passed++;
    #2 rst_i = 1'b1;
    #1;
    total++; if (out_valid_o !== 1'b0 || count_o !== 3'd0 || imm_o !== 32'd0)
      $display("FAIL arst_async got v %b cnt %0d imm %h want 0/0/0", out_valid_o, count_o, imm_o); else passed++;
    #2 rst_i = 1'b0;
    in_valid_i = 1'b1; out_ready_i = 1'b1; instruc_i = 32'h00510093;
    step();
    in_valid_i = 1'b0;
    total++; if (out_valid_o !== 1'b1 || rd_o !== 5'd1 || rs1_o !== 5'd2 || imm_o !== 32'd5 || alu_op_type_o !== ADDI)
      $display("FAIL arst_after got v %b rd %0d rs1 %0d imm %h op %0d want 1/1/2/5/ADDI", out_valid_o, rd_o, rs1_o, imm_o, alu_op_type_o); else passed++;
    step();
  endtask

  task automatic test_imm();
    out_ready_i = 1'b1; in_valid_i = 1'b1; instruc_i = 32'hFFF10093;
    step();
    instruc_i = 32'h01F11093;
    total++; if (imm_o !== 32'hFFFFFFFF || func_group_o !== ALU || alu_op_type_o !== ADDI)
      $display("FAIL imm_neg got imm %h %0d/%0d want ffffffff ALU/ADDI", imm_o, func_group_o, alu_op_type_o); else passed++;
    step();
    in_valid_i = 1'b0;
    total++; if (imm_o !== 32'h1F || func_group_o !== SHIFT || shift_op_type_o !== SLLI || illegal_o !== 1'b0)
      $display("FAIL imm_shamt got imm %h %0d/%0d ill %b want 1f SHIFT/SLLI/0", imm_o, func_group_o, shift_op_type_o, illegal_o); else passed++;
    step();
    out_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_wrap();
    test_flush();
    test_async_reset();
    test_imm();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
